sdram_burst_reader: RTL and testbench

Parametrised successor to the single-address SDRAM reader: fetches a programmable run of INTERFACE_WIDTH_BITS words from the external Avalon bridge (base address, word count, byte stride) into an on-chip FIFO and presents them to a consumer (MAC, VGA, image loader) over valid/ready. It sits between the QSYS bridge and any datapath needing streamed SDRAM data. It replaces the hard-coded image/weight address sequences with per-job descriptors, FIFO backpressure, abort, and protocol-error detection.

---
 rtl/sdram_reader_pkg.sv | 20 ++
 rtl/sdram_burst_reader_sync_fifo.sv | 60 ++++++
 rtl/sdram_burst_reader.sv | 174 +++++++++++++++++
 tb/tb_sdram_burst_reader.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_reader_pkg.sv
// Shared types and helpers for the SDRAM burst reader and its FIFO.
package sdram_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_SPACE = 3'd1,
    ST_REQ        = 3'd2,
    ST_GAP        = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  // Fill bit for the bridge byte-enable bus (every lane always enabled).
  localparam logic BYTE_ENABLE_BIT = 1'b1;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int unsigned fifo_level_bits(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sdram_burst_reader_sync_fifo.sv
// Single-clock FIFO with synchronous flush; head word is read from the
// storage registers and forced to zero while the FIFO is empty.
module sync_fifo
  import sdram_reader_pkg::*;
#(
  parameter  int unsigned WIDTH   = 128,
  parameter  int unsigned DEPTH   = 64,
  localparam int unsigned LEVEL_W = fifo_level_bits(DEPTH),
  localparam int unsigned PTR_W   = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [WIDTH-1:0]   o_data,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_full,
  output logic               o_empty
);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LEVEL_W-1:0] r_level;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_level == LEVEL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_level = r_level;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the FIFO outright.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  // Storage array; contents are don't-care until the level covers them.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/sdram_burst_reader.sv
// Descriptor-driven SDRAM reader: walks base/stride/count over the Avalon
// bridge, one read outstanding at a time, buffering words in a FIFO.
module sdram_burst_reader
  import sdram_reader_pkg::*;
#(
  parameter  int unsigned INTERFACE_WIDTH_BITS = 128,
  parameter  int unsigned NUM_BUFFER_ENTRIES   = 64,
  parameter  int unsigned INTERFACE_ADDR_BITS  = 26,
  parameter  int unsigned COUNT_BITS           = 16,
  localparam int unsigned LEVEL_W              = fifo_level_bits(NUM_BUFFER_ENTRIES)
) (
  input  logic                              interface_clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [INTERFACE_ADDR_BITS-1:0]    base_address,
  input  logic [COUNT_BITS-1:0]             word_count,
  input  logic [INTERFACE_ADDR_BITS-1:0]    stride,
  input  logic                              abort,
  output logic                              busy,
  output logic                              done,
  output logic                              aborted,
  output logic [INTERFACE_ADDR_BITS-1:0]    interface_address,
  output logic [INTERFACE_WIDTH_BITS/8-1:0] interface_byte_enable,
  output logic                              interface_read,
  output logic                              interface_write,
  input  logic [INTERFACE_WIDTH_BITS-1:0]   interface_read_data,
  input  logic                              interface_acknowledge,
  output logic                              out_valid,
  output logic [INTERFACE_WIDTH_BITS-1:0]   out_data,
  input  logic                              out_ready,
  output logic [LEVEL_W-1:0]                fifo_level,
  output logic                              protocol_error
);

  state_t                         r_state;
  state_t                         w_next_state;
  logic [INTERFACE_ADDR_BITS-1:0] r_addr;
  logic [INTERFACE_ADDR_BITS-1:0] r_stride;
  logic [COUNT_BITS-1:0]          r_words_left;
  logic                           r_abort_pending;
  logic                           r_aborted;
  logic                           r_protocol_error;
  logic                           w_start_ok;
  logic                           w_push;
  logic                           w_flush;
  logic                           w_abort_exit;
  logic                           w_fifo_full;
  logic                           w_fifo_empty;

  assign w_start_ok            = (r_state == ST_IDLE) && start;
  assign busy                  = (r_state != ST_IDLE);
  assign done                  = (r_state == ST_DONE);
  assign aborted               = (r_state == ST_DONE) && r_aborted;
  assign interface_read        = (r_state == ST_REQ);
  assign interface_address     = r_addr;
  assign interface_byte_enable = {(INTERFACE_WIDTH_BITS/8){BYTE_ENABLE_BIT}};
  assign interface_write       = 1'b0;
  assign out_valid             = ~w_fifo_empty;
  assign protocol_error        = r_protocol_error;

  // Next-state, FIFO push and flush decisions for the fetch sequencer.
  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    w_abort_exit = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (abort) w_flush = 1'b1;
        if (start) begin
          // An empty job passes through GAP so done lands two cycles after
          // start, the same spacing as after a final acknowledge.
          if (word_count == '0)  w_next_state = ST_GAP;
          else if (!w_fifo_full) w_next_state = ST_REQ;
          else                   w_next_state = ST_WAIT_SPACE;
        end
      end
      ST_WAIT_SPACE: begin
        if (abort) begin
          w_flush      = 1'b1;
          w_abort_exit = 1'b1;
          w_next_state = ST_DONE;
        end else if (!w_fifo_full) begin
          w_next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        if (interface_acknowledge) begin
          if (abort || r_abort_pending) begin
            w_flush      = 1'b1;
            w_abort_exit = 1'b1;
            w_next_state = ST_DONE;
          end else begin
            w_push       = 1'b1;
            w_next_state = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          w_flush      = 1'b1;
          w_abort_exit = 1'b1;
          w_next_state = ST_DONE;
        end else if (r_words_left == '0) begin
          w_next_state = ST_DONE;
        end else if (!w_fifo_full) begin
          w_next_state = ST_REQ;
        end else begin
          w_next_state = ST_WAIT_SPACE;
        end
      end
      ST_DONE: begin
        if (abort) w_flush = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Sequencer state, descriptor latch and address/count advance per word.
  always_ff @(posedge interface_clock or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_stride        <= '0;
      r_words_left    <= '0;
      r_abort_pending <= 1'b0;
      r_aborted       <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_start_ok) begin
        r_addr          <= base_address;
        r_stride        <= stride;
        r_words_left    <= word_count;
        r_abort_pending <= 1'b0;
        r_aborted       <= 1'b0;
      end
      if (w_push) begin
        r_addr       <= r_addr + r_stride;
        r_words_left <= r_words_left - 1'b1;
      end
      if ((r_state == ST_REQ) && abort) r_abort_pending <= 1'b1;
      if (w_abort_exit) r_aborted <= 1'b1;
    end
  end

  // Sticky flag for an acknowledge arriving with no read in flight.
  always_ff @(posedge interface_clock or posedge reset) begin
    if (reset) begin
      r_protocol_error <= 1'b0;
    end else if (interface_acknowledge && (r_state != ST_REQ)) begin
      r_protocol_error <= 1'b1;
    end else if (w_start_ok) begin
      r_protocol_error <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (INTERFACE_WIDTH_BITS),
    .DEPTH (NUM_BUFFER_ENTRIES)
  ) u_fifo (
    .i_clk   (interface_clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_data  (interface_read_data),
    .i_pop   (out_valid & out_ready),
    .i_flush (w_flush),
    .o_data  (out_data),
    .o_level (fifo_level),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Bench for sdram_burst_reader: bridge responder with random latency and data,
// consumer with selectable backpressure, queue-based reference model.
module tb_sdram_burst_reader;

  localparam int unsigned W     = 128;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 26;
  localparam int unsigned CB    = 16;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_address = '0;
  logic [CB-1:0] word_count = '0;
  logic [AW-1:0] stride = '0;
  logic          abort;
  logic          abort_drive = 1'b0;
  logic          busy, done, aborted;
  logic [AW-1:0] interface_address;
  logic [W/8-1:0] interface_byte_enable;
  logic          interface_read, interface_write;
  logic [W-1:0]  interface_read_data = '0;
  logic          interface_acknowledge;
  logic          ack_resp = 1'b0;
  logic          ack_force = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b0;
  logic [LW-1:0] fifo_level;
  logic          protocol_error;

  assign abort                 = abort_drive;
  assign interface_acknowledge = ack_resp | ack_force;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [AW-1:0] exp_addr[$];
  logic [W-1:0]  exp_data[$];
  int            read_cyc[$];
  int            job_reads = 0;
  int            last_ack_cyc = 0;
  logic [AW-1:0] last_addr = '0;
  int            ready_mode = 0;
  bit            lat_rand = 1'b0;
  int            lat_fixed = 3;
  int            abort_at = 0;
  bit            in_req = 1'b0;
  int            wcnt = 0;
  int            cur_lat = 0;

  sdram_burst_reader #(
    .INTERFACE_WIDTH_BITS (W),
    .NUM_BUFFER_ENTRIES   (DEPTH),
    .INTERFACE_ADDR_BITS  (AW),
    .COUNT_BITS           (CB)
  ) dut (
    .interface_clock       (clk),
    .reset                 (reset),
    .start                 (start),
    .base_address          (base_address),
    .word_count            (word_count),
    .stride                (stride),
    .abort                 (abort),
    .busy                  (busy),
    .done                  (done),
    .aborted               (aborted),
    .interface_address     (interface_address),
    .interface_byte_enable (interface_byte_enable),
    .interface_read        (interface_read),
    .interface_write       (interface_write),
    .interface_read_data   (interface_read_data),
    .interface_acknowledge (interface_acknowledge),
    .out_valid             (out_valid),
    .out_data              (out_data),
    .out_ready             (out_ready),
    .fifo_level            (fifo_level),
    .protocol_error        (protocol_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bridge model: checks each new read address, acknowledges after a latency.
  always @(negedge clk) begin
    ack_resp    = 1'b0;
    abort_drive = 1'b0;
    if (reset) begin
      in_req = 1'b0;
      wcnt   = 0;
    end else begin
      if (in_req) chk("read_held", W'(interface_read), W'(1));
      if (interface_read) begin
        if (!in_req) begin
          in_req = 1'b1;
          wcnt   = 0;
          job_reads++;
          read_cyc.push_back(cyc);
          cur_lat   = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
          last_addr = interface_address;
          if (exp_addr.size() == 0) chk("addr_unexpected", W'(1), W'(0));
          else chk("read_addr", W'(interface_address), W'(exp_addr.pop_front()));
          if (abort_at != 0 && job_reads == abort_at) abort_drive = 1'b1;
        end
        if (wcnt == cur_lat) begin
          ack_resp            = 1'b1;
          interface_read_data = {$urandom, $urandom, $urandom, $urandom};
          exp_data.push_back(interface_read_data);
          last_ack_cyc = cyc;
          in_req       = 1'b0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Consumer model: picks out_ready for the coming edge and checks popped words.
  always @(negedge clk) begin
    if (reset) begin
      out_ready = 1'b0;
    end else begin
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_ready && out_valid) begin
        if (exp_data.size() == 0) chk("pop_unexpected", W'(1), W'(0));
        else chk("out_data", out_data, exp_data.pop_front());
      end
    end
  end

  task automatic start_job(input logic [AW-1:0] b, input int unsigned n,
                           input logic [AW-1:0] s, output int s_cyc);
    @(negedge clk);
    base_address = b;
    word_count   = CB'(n);
    stride       = s;
    start        = 1'b1;
    s_cyc        = cyc;
    job_reads    = 0;
    read_cyc.delete();
    for (int unsigned i = 0; i < n; i++) exp_addr.push_back(AW'(b + i * s));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int d_cyc, output logic d_ab);
    bit found = 1'b0;
    d_cyc = -1;
    d_ab  = 1'bx;
    repeat (2000) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        d_cyc = cyc;
        d_ab  = aborted;
        break;
      end
    end
    chk("done_seen", W'(found), W'(1));
  endtask

  task automatic drain();
    repeat (500) begin
      @(negedge clk);
      if (exp_data.size() == 0 && !out_valid) break;
    end
    chk("drain_model_empty", W'(exp_data.size()), W'(0));
    chk("drain_out_valid", W'(out_valid), W'(0));
  endtask

  initial begin
    int   s_cyc;
    int   d_cyc;
    logic d_ab;
    int unsigned n;
    logic [AW-1:0] b;
    logic [AW-1:0] s;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_read", W'(interface_read), W'(0));
    chk("rst_write", W'(interface_write), W'(0));
    chk("rst_addr", W'(interface_address), W'(0));
    chk("rst_be", W'(interface_byte_enable), W'(16'hFFFF));
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_level", W'(fifo_level), W'(0));
    chk("rst_perr", W'(protocol_error), W'(0));
    reset = 1'b0;

    // Basic 4-word job, fixed latency 3, consumer always ready
    ready_mode = 1; lat_rand = 1'b0; lat_fixed = 3;
    start_job(26'h100, 4, 26'h10, s_cyc);
    chk("t1_busy", W'(busy), W'(1));
    chk("t1_read", W'(interface_read), W'(1));
    wait_done(d_cyc, d_ab);
    chk("t1_done_latency", W'(d_cyc), W'(last_ack_cyc + 2));
    chk("t1_aborted", W'(d_ab), W'(0));
    chk("t1_first_read_cyc", W'(read_cyc[0]), W'(s_cyc + 1));
    chk("t1_reread_gap", W'(read_cyc[1] - read_cyc[0]), W'(5));
    drain();
    chk("t1_reads", W'(job_reads), W'(4));

    // Zero-length job
    start_job(26'h200, 0, 26'h10, s_cyc);
    chk("t2_busy", W'(busy), W'(1));
    wait_done(d_cyc, d_ab);
    chk("t2_done_cyc", W'(d_cyc), W'(s_cyc + 2));
    chk("t2_aborted", W'(d_ab), W'(0));
    chk("t2_no_reads", W'(job_reads), W'(0));

    // FIFO full backpressure: only DEPTH reads while consumer stalls
    ready_mode = 0; lat_rand = 1'b1;
    start_job(AW'($urandom), 10, AW'($urandom), s_cyc);
    repeat (60) @(negedge clk);
    chk("t3_reads_stalled", W'(job_reads), W'(DEPTH));
    chk("t3_read_idle", W'(interface_read), W'(0));
    chk("t3_level_full", W'(fifo_level), W'(DEPTH));
    ready_mode = 2;
    wait_done(d_cyc, d_ab);
    chk("t3_aborted", W'(d_ab), W'(0));
    drain();
    chk("t3_reads", W'(job_reads), W'(10));

    // Address wrap at 2^26
    ready_mode = 1;
    start_job(26'h3FFFFF0, 2, 26'h10, s_cyc);
    wait_done(d_cyc, d_ab);
    drain();
    chk("t4_wrap_addr", W'(last_addr), W'(0));

    // Abort while the third read is pending
    ready_mode = 0; lat_rand = 1'b0; lat_fixed = 3; abort_at = 3;
    start_job(26'h4000, 8, 26'h40, s_cyc);
    wait_done(d_cyc, d_ab);
    chk("t5_aborted", W'(d_ab), W'(1));
    chk("t5_valid", W'(out_valid), W'(0));
    chk("t5_level", W'(fifo_level), W'(0));
    chk("t5_reads", W'(job_reads), W'(3));
    abort_at = 0;
    exp_addr.delete();
    exp_data.delete();
    @(negedge clk);
    chk("t5_idle", W'(busy), W'(0));

    // Stray acknowledge in IDLE
    ready_mode = 1;
    @(negedge clk); ack_force = 1'b1;
    @(negedge clk); ack_force = 1'b0;
    chk("t6_perr_set", W'(protocol_error), W'(1));
    repeat (3) @(negedge clk);
    chk("t6_perr_sticky", W'(protocol_error), W'(1));
    start_job(26'h800, 1, 26'h10, s_cyc);
    chk("t6_perr_clear", W'(protocol_error), W'(0));
    wait_done(d_cyc, d_ab);
    drain();

    // Randomized jobs
    lat_rand = 1'b1; ready_mode = 2;
    for (int j = 0; j < 4; j++) begin
      b = AW'($urandom);
      s = AW'($urandom);
      n = $urandom_range(1, 12);
      start_job(b, n, s, s_cyc);
      wait_done(d_cyc, d_ab);
      chk("t7_aborted", W'(d_ab), W'(0));
      drain();
      chk("t7_reads", W'(job_reads), W'(n));
    end

    // Reset in the middle of a job
    ready_mode = 1; lat_rand = 1'b0; lat_fixed = 3;
    start_job(26'h1000, 8, 26'h10, s_cyc);
    repeat (100) begin
      @(negedge clk);
      if (interface_read && job_reads >= 2) break;
    end
    chk("t8_mid_read", W'(interface_read), W'(1));
    reset = 1'b1;
    #1;
    in_req = 1'b0;
    chk("t8_read", W'(interface_read), W'(0));
    chk("t8_busy", W'(busy), W'(0));
    chk("t8_done", W'(done), W'(0));
    chk("t8_valid", W'(out_valid), W'(0));
    chk("t8_level", W'(fifo_level), W'(0));
    chk("t8_addr", W'(interface_address), W'(0));
    exp_addr.delete();
    exp_data.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start_job(26'h2000, 2, 26'h20, s_cyc);
    wait_done(d_cyc, d_ab);
    chk("t8_recover_aborted", W'(d_ab), W'(0));
    drain();
    chk("t8_recover_reads", W'(job_reads), W'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
